// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin share of one uart_tx_8n1 between NUM_REQ byte producers.
// Latency: req_ready pulses in the IDLE grant cycle; send_enable rises on the next cycle.
// Backpressure: requesters hold valid/data until ready; no grant outside IDLE (LAUNCH/DRAIN/GAP).
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int LAUNCH_TIMEOUT = 4095
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   uart_busy,
    output logic                   send_enable,
    output logic [7:0]             send_data,
    output logic [2:0]             grant_id,
    output logic                   tx_active,
    output logic                   timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_DRAIN  = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    // Gap counter holds GAP_CYCLES-1 down to 0, so it only needs clog2(GAP_CYCLES) bits.
    localparam int             GW         = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]  GAP_LOAD   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit             HAS_GAP    = (GAP_CYCLES > 0);
    localparam logic [11:0]    TIMER_LAST = 12'((LAUNCH_TIMEOUT > 0) ? LAUNCH_TIMEOUT - 1 : 0);
    localparam logic [2:0]     LAST_IDX   = 3'(NUM_REQ - 1);
    localparam logic [3:0]     NREQ       = 4'(NUM_REQ);

    state_t          state_q;
    state_t          state_d;
    logic            busy_meta;
    logic            busy_s;
    logic [2:0]      rr_q;
    logic [11:0]     timer_q;
    logic [GW-1:0]   gap_q;

    // Requester vectors widened to the 8-requester maximum so a 3-bit index is always legal.
    logic [7:0]      valid_pad;
    logic [63:0]     data_pad;
    logic            found;
    logic [2:0]      win_idx;
    logic [3:0]      cand;
    logic            grant;
    logic            timer_done;

    assign valid_pad  = 8'(req_valid);
    assign data_pad   = 64'(req_data);
    assign grant      = rst_n && (state_q == S_IDLE) && found;
    assign timer_done = (timer_q == TIMER_LAST);

    // Bring the baud-domain busy flag into clk before any decision looks at it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_meta <= 1'b0;
            busy_s    <= 1'b0;
        end else begin
            busy_meta <= uart_busy;
            busy_s    <= busy_meta;
        end
    end

    // Round-robin search: first valid requester at or after rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        found   = 1'b0;
        win_idx = 3'd0;
        cand    = 4'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_q} + 4'(i);
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && valid_pad[cand[2:0]]) begin
                found   = 1'b1;
                win_idx = cand[2:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a busy seen in LAUNCH wins over a timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (busy_s) begin
                    state_d = S_DRAIN;
                end else if (timer_done) begin
                    state_d = HAS_GAP ? S_GAP : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (!busy_s) begin
                    state_d = HAS_GAP ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; req_ready is the one-hot grant of the IDLE cycle.
    always_comb begin
        req_ready   = '0;
        send_enable = 1'b0;
        timeout_err = 1'b0;
        tx_active   = (state_q != S_IDLE);
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant && (win_idx == 3'(i));
        end
        if (state_q == S_LAUNCH) begin
            send_enable = 1'b1;
            timeout_err = !busy_s && timer_done;
        end
    end

    // Grant bookkeeping plus launch timer and gap counter; the byte is only latched on a grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            send_data <= 8'd0;
            grant_id  <= 3'd0;
            rr_q      <= 3'd0;
            timer_q   <= 12'd0;
            gap_q     <= '0;
        end else begin
            if (grant) begin
                send_data <= data_pad[{win_idx, 3'b000} +: 8];
                grant_id  <= win_idx;
                rr_q      <= (win_idx == LAST_IDX) ? 3'd0 : win_idx + 3'd1;
            end
            // Timer restarts from zero every time LAUNCH is entered.
            if (state_q == S_LAUNCH) begin
                timer_q <= timer_q + 12'd1;
            end else begin
                timer_q <= 12'd0;
            end
            // Counter sits preloaded outside GAP and counts down inside it.
            if (state_q == S_GAP) begin
                gap_q <= gap_q - GW'(1);
            end else begin
                gap_q <= GAP_LOAD;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a GAP_CYCLES=16 instance with a short launch timeout,
// plus a GAP_CYCLES=0 instance for back-to-back frames. Each instance has its own
// behavioural busy model; a grant monitor feeds the byte scoreboard.
module tb_uart_tx_arbiter;

    localparam int BUSY_DLY  = 5;   // model: cycles from seeing send_enable to raising busy
    localparam int FRAME     = 10;  // model: cycles busy stays high
    localparam int GAP       = 16;
    localparam int TIMEOUT   = 20;
    localparam int BUSY_DLY0 = 2;
    localparam int FRAME0    = 6;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        uart_busy;
    logic        send_enable;
    logic [7:0]  send_data;
    logic [2:0]  grant_id;
    logic        tx_active;
    logic        timeout_err;

    logic [3:0]  req_valid0;
    logic [31:0] req_data0;
    logic [3:0]  req_ready0;
    logic        uart_busy0;
    logic        send_enable0;
    logic [7:0]  send_data0;
    logic [2:0]  grant_id0;
    logic        tx_active0;
    logic        timeout_err0;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [7:0]  exp_q[$];
    bit          model_en;
    int          rr_m;
    int          mon_k;
    int          ms, dly, frm;
    int          ms0, dly0, frm0;
    int          n, se, act, tos;
    int          order[5] = '{0, 1, 2, 3, 0};

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(GAP), .LAUNCH_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .uart_busy(uart_busy), .send_enable(send_enable),
        .send_data(send_data), .grant_id(grant_id), .tx_active(tx_active),
        .timeout_err(timeout_err)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(0), .LAUNCH_TIMEOUT(TIMEOUT)) dut_nogap (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_data(req_data0),
        .req_ready(req_ready0), .uart_busy(uart_busy0), .send_enable(send_enable0),
        .send_data(send_data0), .grant_id(grant_id0), .tx_active(tx_active0),
        .timeout_err(timeout_err0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    task automatic wait_ready(input string tag, input int limit, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (req_ready == 4'b0 && cnt < limit);
        check_eq({tag, "_ready_seen"}, 32'(req_ready != 4'b0), 1);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int cnt;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (tx_active && cnt < limit);
        check_eq({tag, "_idle"}, 32'(tx_active), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Grant monitor: reference round-robin over the driven valids; pushes the expected byte.
    initial begin
        rr_m = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rr_m = 0;
            end else if (req_ready != 4'b0) begin
                mon_k = -1;
                for (int i = 0; i < 4; i++) begin
                    if (mon_k < 0 && req_valid[(rr_m + i) % 4]) mon_k = (rr_m + i) % 4;
                end
                check_eq("mon_grant_valid", 32'(mon_k >= 0), 1);
                if (mon_k >= 0) begin
                    check_eq("mon_ready_mask", 32'(req_ready), 32'(4'b0001 << mon_k));
                    rr_m = (mon_k + 1) % 4;
                    if (model_en) exp_q.push_back(req_data[8*mon_k +: 8]);
                end
            end
        end
    end

    // UART busy model for the main instance; the transmitter is never aborted by reset.
    initial begin
        uart_busy = 1'b0;
        ms = 0; dly = 0; frm = 0;
        forever begin
            @(negedge clk);
            if (ms == 0) begin
                if (send_enable && model_en) begin
                    check_eq("uart_frame_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) check_eq("uart_byte", 32'(send_data), 32'(exp_q.pop_front()));
                    dly = BUSY_DLY;
                    ms  = 1;
                end
            end else if (ms == 1) begin
                dly--;
                if (dly == 0) begin
                    #1 uart_busy = 1'b1;
                    frm = FRAME;
                    ms  = 2;
                end
            end else begin
                frm--;
                if (frm == 0) begin
                    #1 uart_busy = 1'b0;
                    ms = 0;
                end
            end
        end
    end

    // UART busy model for the zero-gap instance; requester 1 always sends 8'h5A there.
    initial begin
        uart_busy0 = 1'b0;
        ms0 = 0; dly0 = 0; frm0 = 0;
        forever begin
            @(negedge clk);
            if (ms0 == 0) begin
                if (send_enable0) begin
                    check_eq("t6_byte", 32'(send_data0), 32'h5A);
                    dly0 = BUSY_DLY0;
                    ms0  = 1;
                end
            end else if (ms0 == 1) begin
                dly0--;
                if (dly0 == 0) begin
                    #1 uart_busy0 = 1'b1;
                    frm0 = FRAME0;
                    ms0  = 2;
                end
            end else begin
                frm0--;
                if (frm0 == 0) begin
                    #1 uart_busy0 = 1'b0;
                    ms0 = 0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, want finish before 400000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        model_en   = 1'b1;
        req_valid  = 4'hF;
        req_data   = 32'h13121110;
        req_valid0 = 4'h0;
        req_data0  = 32'h0;

        // 1: reset holds every output low even with all requesters valid
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", 32'(req_ready), 0);
        check_eq("rst_outputs", {send_enable, tx_active, timeout_err, grant_id, send_data}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1 req_valid = 4'h0;
        @(negedge clk);
        check_eq("rel_send_enable", 32'(send_enable), 1);
        check_eq("rel_send_data", 32'(send_data), 32'h10);
        wait_idle("t1", 200);

        // 2: single requester; enable holds until synchronized busy, then drain + gap
        @(posedge clk); #1 req_valid = 4'b0100; req_data[23:16] = 8'hA5;
        wait_ready("t2", 10, n);
        check_eq("t2_ready", 32'(req_ready), 32'h4);
        check_eq("t2_no_enable_in_grant", 32'(send_enable), 0);
        @(posedge clk); #1 req_valid = 4'h0;
        se = 0; act = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check_eq("t2_accept_to_enable", 32'(send_enable), 1);
                check_eq("t2_grant_id", 32'(grant_id), 2);
            end
            if (!tx_active) break;
            act++;
            if (send_enable) se++;
        end
        check_eq("t2_enable_cycles", se, BUSY_DLY + 3);
        check_eq("t2_active_cycles", act, BUSY_DLY + 3 + FRAME + GAP);

        // 3: all requesters valid from a fresh pointer: order 0,1,2,3,0 at full frame spacing
        do_reset();
        @(posedge clk); #1 req_valid = 4'hF; req_data = 32'h13121110;
        for (int g = 0; g < 5; g++) begin
            wait_ready("t3", 60, n);
            check_eq("t3_order", 32'(req_ready), 32'(4'b0001 << order[g]));
            if (g > 0) check_eq("t3_spacing", n, BUSY_DLY + 3 + FRAME + GAP + 1);
        end
        @(posedge clk); #1 req_valid = 4'h0;
        wait_idle("t3", 200);

        // 4: busy never rises: launch times out, gap still applies, pointer has advanced
        @(posedge clk); #1 model_en = 1'b0; req_valid = 4'b0011;
        wait_ready("t4", 10, n);
        check_eq("t4_first", 32'(req_ready), 32'h2);
        se = 0; tos = 0; n = 0;
        do begin
            @(negedge clk);
            n++;
            if (send_enable) se++;
            if (timeout_err) tos++;
        end while (req_ready == 4'b0 && n < 80);
        check_eq("t4_enable_cycles", se, TIMEOUT);
        check_eq("t4_timeout_pulses", tos, 1);
        check_eq("t4_spacing", n, 1 + TIMEOUT + GAP);
        check_eq("t4_second", 32'(req_ready), 32'h1);
        @(posedge clk); #1 req_valid = 4'h0;
        wait_idle("t4", 200);
        @(posedge clk); #1 model_en = 1'b1;

        // 5: reset while draining; arbiter restarts clean and the next frame completes
        @(posedge clk); #1 req_valid = 4'b0100;
        wait_ready("t5", 10, n);
        @(posedge clk); #1 req_valid = 4'h0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!uart_busy && n < 30);
        repeat (3) @(negedge clk);
        check_eq("t5_in_drain", {tx_active, send_enable}, 2'b10);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("t5_rst_outputs", {send_enable, tx_active, timeout_err, grant_id, send_data}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (uart_busy && n < 30);
        @(posedge clk); #1 req_valid = 4'b1100;
        wait_ready("t5", 10, n);
        check_eq("t5_rr_reset", 32'(req_ready), 32'h4);
        @(posedge clk); #1 req_valid = 4'h0;
        wait_idle("t5", 200);

        // 6: zero gap, requester 1 always valid: grant one cycle after busy_s falls
        @(posedge clk); #1 req_valid0 = 4'b0010; req_data0 = 32'h00005A00;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready0 == 4'b0 && n < 10);
        check_eq("t6_first", 32'(req_ready0), 32'h2);
        for (int f = 0; f < 3; f++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (req_ready0 == 4'b0 && n < 60);
            check_eq("t6_spacing", n, BUSY_DLY0 + 3 + FRAME0 + 1);
        end
        @(posedge clk); #1 req_valid0 = 4'h0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_active0 && n < 60);
        check_eq("t6_idle", 32'(tx_active0), 0);

        check_eq("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
